// File: rtl/lpm_div_pkg.sv
// Shared types, default widths and saturation helpers for the sequential
// restoring divider lpm_div_seq_32_16.
package lpm_div_pkg;

    localparam int DEF_WIDTHA = 32;
    localparam int DEF_WIDTHB = 16;

    localparam REP_SIGNED   = "SIGNED";
    localparam REP_UNSIGNED = "UNSIGNED";

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX
    } div_state_e;

    // Saturation patterns for a w-bit result, returned zero-extended to 64 bits.
    function automatic logic [63:0] sat_max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] sat_all_ones(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/lpm_div_seq_32_16_div_restore_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_restore_step
    import lpm_div_pkg::*;
#(
    parameter int WIDTHB = DEF_WIDTHB
) (
    input  logic [WIDTHB:0]   part_rem,
    input  logic [WIDTHB-1:0] divisor,
    output logic [WIDTHB-1:0] next_rem,
    output logic              q_bit
);

    assign q_bit    = (part_rem >= {1'b0, divisor});
    assign next_rem = q_bit ? WIDTHB'(part_rem - {1'b0, divisor}) : part_rem[WIDTHB-1:0];

endmodule

// File: rtl/lpm_div_seq_32_16.sv
// Sequential restoring divider, one quotient bit per clock, fixed latency.
// Optional Abort input enabled by defining LPM_DIV_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for Start; operands captured as magnitudes on accept
// CALC  | WIDTHA restoring iterations on the magnitudes
// FIX   | apply signs, saturate, register results, pulse Done
module lpm_div_seq_32_16
    import lpm_div_pkg::*;
#(
    parameter int WIDTHA         = DEF_WIDTHA,
    parameter int WIDTHB         = DEF_WIDTHB,
    parameter     REPRESENTATION = REP_SIGNED
) (
    input  logic              Clock,
    input  logic              Aclr_n,
`ifdef LPM_DIV_ABORT_EN
    input  logic              Abort,
`endif
    input  logic              Start,
    input  logic [WIDTHA-1:0] Dividend,
    input  logic [WIDTHB-1:0] Divisor,
    output logic              Busy,
    output logic              Done,
    output logic [WIDTHB-1:0] Quotient,
    output logic [WIDTHB-1:0] Remainder,
    output logic              Overflow,
    output logic              DivZero
);

    localparam bit IS_SIGNED = (REPRESENTATION != REP_UNSIGNED);
    localparam int CNT_W     = $clog2(WIDTHA);

    // Overflow limits on the WIDTHA-bit magnitude quotient.
    localparam logic [WIDTHA-1:0] LIM_POS = WIDTHA'(sat_max_pos(WIDTHB));
    localparam logic [WIDTHA-1:0] LIM_NEG = WIDTHA'(sat_min_neg(WIDTHB));
    localparam logic [WIDTHA-1:0] LIM_U   = WIDTHA'(sat_all_ones(WIDTHB));
    localparam logic [WIDTHB-1:0] Q_MAX   = WIDTHB'(sat_max_pos(WIDTHB));
    localparam logic [WIDTHB-1:0] Q_MIN   = WIDTHB'(sat_min_neg(WIDTHB));
    localparam logic [WIDTHB-1:0] Q_ONES  = WIDTHB'(sat_all_ones(WIDTHB));

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTHA-1:0] quo;
    logic [WIDTHB-1:0] rem;
    logic [WIDTHB-1:0] div_mag;
    logic              neg_q;
    logic              neg_r;

    logic              a_neg;
    logic              b_neg;
    logic [WIDTHA-1:0] a_mag;
    logic [WIDTHB-1:0] b_mag;
    logic [WIDTHB-1:0] step_rem;
    logic              step_q;
    logic              abort_req;

    logic              dz_fix;
    logic              ovf_fix;
    logic [WIDTHB-1:0] q_lo;
    logic [WIDTHB-1:0] q_fix;
    logic [WIDTHB-1:0] r_fix;

`ifdef LPM_DIV_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    // Magnitudes are kept full width so the most-negative operand does not wrap.
    assign a_neg = IS_SIGNED && Dividend[WIDTHA-1];
    assign b_neg = IS_SIGNED && Divisor[WIDTHB-1];
    assign a_mag = a_neg ? -Dividend : Dividend;
    assign b_mag = b_neg ? -Divisor : Divisor;

    assign Busy = (state != IDLE);

    div_restore_step #(
        .WIDTHB (WIDTHB)
    ) u_step (
        .part_rem (    {rem, quo[WIDTHA-1]}),
        .divisor  (div_mag),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        dz_fix = (div_mag == '0);
        q_lo   = quo[WIDTHB-1:0];
        if (IS_SIGNED) begin
            ovf_fix = neg_q ? (quo > LIM_NEG) : (quo > LIM_POS);
        end else begin
            ovf_fix = (quo > LIM_U);
        end
        ovf_fix = ovf_fix && !dz_fix;

        if (dz_fix) begin
            q_fix = '0;
        end else if (ovf_fix) begin
            q_fix = IS_SIGNED ? (neg_q ? Q_MIN : Q_MAX) : Q_ONES;
        end else begin
            q_fix = neg_q ? -q_lo : q_lo;
        end

        if (dz_fix) begin
            r_fix = '0;
        end else begin
            r_fix = neg_r ? -rem : rem;
        end
    end

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            state     <= IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            div_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Overflow  <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (abort_req && state != IDLE) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            quo     <= a_mag;
                            rem     <= '0;
                            div_mag <= b_mag;
                            neg_r   <= a_neg;
                            neg_q   <= a_neg ^ b_neg;
                            cnt     <= CNT_W'(WIDTHA - 1);
                            state   <= CALC;
                        end
                    end
                    CALC: begin
                        quo <= {quo[WIDTHA-2:0], step_q};
                        rem <= step_rem;
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    FIX: begin
                        Quotient  <= q_fix;
                        Remainder <= r_fix;
                        Overflow  <= ovf_fix;
                        DivZero   <= dz_fix;
                        Done      <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
